// File: rtl/my_112l_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package my_112l_pkg;

    typedef enum logic [0:0] {PCTRL_RUN, PCTRL_MD_WAIT} pctrl_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register control outputs of the stall/flush sequencer.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ifid_use_rs1;
    logic             ifid_use_rs2;
    logic             ex_redirect;
    logic             ex_muldiv;
    logic             muldiv_done;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             memwb_bubble;
    logic             muldiv_start;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output idex_memread, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               ex_redirect, ex_muldiv, muldiv_done, dmem_req, dmem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_bubble, exmem_bubble, memwb_bubble, muldiv_start, stall_cycles
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               ex_redirect, ex_muldiv, muldiv_done, dmem_req, dmem_ready,
        output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_bubble, exmem_bubble, memwb_bubble, muldiv_start, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Detects an ID instruction reading the destination of a load currently in EX.
import my_112l_pkg::*;

module load_use_detect (
    input  logic       idex_memread,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_use_rs1,
    input  logic       ifid_use_rs2,
    output logic       load_use
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // x0 is never a real dependency, so it cannot cause a stall.
    always_comb begin
        rs1_hit_s = ifid_use_rs1 & (idex_rd == ifid_rs1);
        rs2_hit_s = ifid_use_rs2 & (idex_rd == ifid_rs2);
        load_use  = idex_memread & (idex_rd != REG_X0) & (rs1_hit_s | rs2_hit_s);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Merges memory, MUL/DIV, redirect and load-use hazards into pipeline-register enables.
import my_112l_pkg::*;

module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic     clk,
    input  logic     reset,
    pipeline_ctrl_if.slave bus
);

    logic [0:0]       state_q, state_d;
    logic             md_done_q, md_done_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use_s;
    logic mem_stall_s;
    logic done_eff_s;

    logic pc_write_s, ifid_write_s, idex_write_s, exmem_write_s;
    logic ifid_flush_s, idex_bubble_s, exmem_bubble_s, memwb_bubble_s, muldiv_start_s;

    load_use_detect u_load_use_detect (
        .idex_memread (bus.idex_memread),
        .idex_rd      (bus.idex_rd),
        .ifid_rs1     (bus.ifid_rs1),
        .ifid_rs2     (bus.ifid_rs2),
        .ifid_use_rs1 (bus.ifid_use_rs1),
        .ifid_use_rs2 (bus.ifid_use_rs2),
        .load_use     (load_use_s)
    );

    // Priority resolution of hazard sources and next-state computation.
    always_comb begin
        mem_stall_s    = bus.dmem_req & ~bus.dmem_ready;
        done_eff_s     = bus.muldiv_done | md_done_q;
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        idex_write_s   = 1'b1;
        exmem_write_s  = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        exmem_bubble_s = 1'b0;
        memwb_bubble_s = 1'b0;
        muldiv_start_s = 1'b0;
        state_d        = state_q;
        md_done_d      = md_done_q;

        if (reset) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_write_s  = 1'b0;
            exmem_write_s = 1'b0;
            state_d       = ST_RUN;
            md_done_d     = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall_s) begin
                        pc_write_s     = 1'b0;
                        ifid_write_s   = 1'b0;
                        idex_write_s   = 1'b0;
                        exmem_write_s  = 1'b0;
                        memwb_bubble_s = 1'b1;
                    end else if (bus.ex_muldiv) begin
                        muldiv_start_s = 1'b1;
                        pc_write_s     = 1'b0;
                        ifid_write_s   = 1'b0;
                        idex_write_s   = 1'b0;
                        exmem_bubble_s = 1'b1;
                        state_d        = ST_MD_WAIT;
                    end else if (bus.ex_redirect) begin
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_bubble_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MD_WAIT: begin
                    if (bus.muldiv_done) begin
                        md_done_d = 1'b1;
                    end else begin
                        md_done_d = md_done_q;
                    end
                    if (mem_stall_s) begin
                        pc_write_s     = 1'b0;
                        ifid_write_s   = 1'b0;
                        idex_write_s   = 1'b0;
                        exmem_write_s  = 1'b0;
                        memwb_bubble_s = 1'b1;
                    end else if (!done_eff_s) begin
                        pc_write_s     = 1'b0;
                        ifid_write_s   = 1'b0;
                        idex_write_s   = 1'b0;
                        exmem_bubble_s = 1'b1;
                    end else begin
                        md_done_d = 1'b0;
                        state_d   = ST_RUN;
                    end
                end
                default: begin
                    state_d   = ST_RUN;
                    md_done_d = 1'b0;
                end
            endcase
        end

        if (reset) begin
            stall_cycles_d = {CNT_W{1'b0}};
        end else if (!pc_write_s) begin
            stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State, pending-done flag and performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            md_done_q      <= 1'b0;
            stall_cycles_q <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            md_done_q      <= md_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.pc_write     = pc_write_s;
    assign bus.ifid_write   = ifid_write_s;
    assign bus.idex_write   = idex_write_s;
    assign bus.exmem_write  = exmem_write_s;
    assign bus.ifid_flush   = ifid_flush_s;
    assign bus.idex_bubble  = idex_bubble_s;
    assign bus.exmem_bubble = exmem_bubble_s;
    assign bus.memwb_bubble = memwb_bubble_s;
    assign bus.muldiv_start = muldiv_start_s;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). Each cycle it merges four stall and flush sources into one consistent set of pipeline-register enables:

- data-memory wait,
- a multi-cycle MUL/DIV unit in EX,
- EX-resolved branch/jump redirect,
- load-use hazards.

It also sequences the MUL/DIV unit through a start/done handshake and keeps a stall-cycle performance counter.

## Interface
Parameters:
- CNT_W, 32, width of stall_cycles counter

Ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- idex_memread  in  1  instruction in EX is a load
- idex_rd  in  5  destination register of EX instruction
- ifid_rs1, ifid_rs2  in  5  source registers of ID instruction
- ifid_use_rs1, ifid_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_redirect  in  1  EX resolved taken branch/jump (PC must load target)
- ex_muldiv  in  1  EX holds a valid MUL/DIV op
- muldiv_done  in  1  MUL/DIV result valid (single-cycle pulse)
- dmem_req  in  1  MEM stage has valid load/store
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register load enable
- ifid_write, idex_write, exmem_write  out  1  pipeline register load enables
- ifid_flush  out  1  IF/ID loads NOP (meaningful only with ifid_write=1)
- idex_bubble  out  1  ID/EX loads NOP controls (with idex_write=1)
- exmem_bubble  out  1  EX/MEM loads NOP controls (with exmem_write=1)
- memwb_bubble  out  1  MEM/WB loads NOP controls
- muldiv_start  out  1  one-cycle start pulse to MUL/DIV unit
- stall_cycles  out  CNT_W  count of cycles with pc_write=0

## Operation
- mem_stall = dmem_req & ~dmem_ready.
- load_use = idex_memread & idex_rd≠0 & ((ifid_use_rs1 & idex_rd==ifid_rs1) | (ifid_use_rs2 & idex_rd==ifid_rs2)).
- Default (no condition active): all *_write=1; all flush/bubble and muldiv_start=0.
- States: RUN, MD_WAIT. Internal flag md_done_q.
- RUN evaluates the following in strict priority order:
  1. mem_stall: pc/ifid/idex/exmem write=0, memwb_bubble=1. No MUL/DIV start. Stay RUN.
  2. ex_muldiv: muldiv_start=1, pc/ifid/idex write=0, exmem_write=1 with exmem_bubble=1. Go to MD_WAIT.
  3. ex_redirect: pc_write=1, ifid_flush=1, idex_bubble=1. A coincident load_use is ignored, because the ID instruction is squashed.
  4. load_use: pc_write=0, ifid_write=0, idex_bubble=1.
- ex_muldiv and ex_redirect are never both valid (same EX slot). ex_muldiv has priority if both assert.
- MD_WAIT:
  - md_done_q is set by muldiv_done. done_eff = muldiv_done | md_done_q.
  - mem_stall: same freeze as RUN; stay.
  - Otherwise, if ~done_eff: pc/ifid/idex write=0, exmem_write=1 with exmem_bubble=1; stay.
  - Otherwise (done_eff & ~mem_stall): release with default outputs (EX/MEM captures result), clear md_done_q, go to RUN.
- muldiv_done in RUN is ignored. muldiv_start is never asserted outside RUN.
- stall_cycles increments (wrapping) each non-reset cycle with pc_write=0.

## Timing
- Write/flush/bubble/start outputs are combinational from state and inputs, valid the same cycle. State, md_done_q and stall_cycles update on posedge clk.
- Load-use stall lasts exactly 1 cycle unless extended by mem_stall.
- MUL/DIV: start in cycle N; release in the cycle done_eff & ~mem_stall first holds (earliest N+1).
- While reset=1:
  - all *_write, flush, bubble and muldiv_start outputs=0;
  - next state RUN, md_done_q=0, stall_cycles=0.
- Reset during MD_WAIT aborts the sequence. The MUL/DIV unit shares the same reset.

## Structure
- my_112l_pkg gains:
  - typedef enum logic [0:0] {PCTRL_RUN, PCTRL_MD_WAIT} pctrl_state_e;
  - localparam REG_X0 = 5'd0.
- One combinational sub-module, load_use_detect, computes load_use. Everything else lives in pipeline_ctrl.

## Test plan
- idex_memread=1, idex_rd=5, ifid_rs1=5, ifid_use_rs1=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1. Same with idex_rd=0, or ifid_use_rs1=0 -> no stall.
- ex_redirect=1 together with a load_use match -> pc_write=1, ifid_flush=1, idex_bubble=1, stall_cycles unchanged.
- ex_muldiv=1 at cycle 0, muldiv_done at cycle 5:
  - muldiv_start high only at cycle 0;
  - exmem_bubble=1 cycles 0–4;
  - all writes=1 at cycle 5;
  - stall_cycles +5.
- MUL/DIV started at cycle 0, mem_stall cycles 3–6, muldiv_done at cycle 4 -> memwb_bubble=1 cycles 3–6, release at cycle 7, md_done_q cleared after.
- dmem_req=1, dmem_ready=0 for 3 cycles -> all writes=0 and memwb_bubble=1 for exactly 3 cycles; 4th cycle default outputs.
- reset asserted 1 cycle while in MD_WAIT -> outputs 0 that cycle; next cycle state RUN, stall_cycles=0, a late muldiv_done ignored.
